lvt_mpram: RTL and testbench
============================

// Module: lvt_mpram
// PURPOSE
//   Parametrised multi-port RAM built from a Live Value Table (LVT): NW write ports, NR read ports.
//   Storage is NW x NR banks; bank[w][r] holds writes from port w and serves read port r.
//   A per-address LVT records the last write port; each read mux selects that port's bank.
//   Generalises the fixed 2W/1R lvt_bram with configurable width, depth and port counts.
//   Adds a post-reset clear sequence, write-collision detection and optional write-to-read bypass.
// PARAMETERS
//   NW      2   number of write ports (>=2)
//   NR      1   number of read ports (>=1)
//   AW      7   address width; DEPTH = 2**AW
//   DW      8   data width
//   BYPASS  0   0: read-during-write returns old data; 1: returns new data
// PORTS
//   clk           in   1        clock; all logic on rising edge
//   rst           in   1        synchronous, active-low reset
//   wr_addr       in   NW*AW    write addresses; port w = [w*AW +: AW]
//   wr_data       in   NW*DW    write data; port w = [w*DW +: DW]
//   wr_en         in   NW       per-port write enable
//   rd_addr       in   NR*AW    read addresses; port r = [r*AW +: AW]
//   rd_en         in   NR       per-port read enable
//   rd_data       out  NR*DW    registered read data
//   rd_valid      out  NR       high for 1 cycle when rd_data[r] was updated
//   ready         out  1        high once the clear sequence completes
//   wr_collision  out  1        1-cycle pulse: >=2 enabled write ports targeted the same address
// BEHAVIOUR
//   Reset (rst==0 at a posedge): FSM -> INIT; clear pointer = 0.
//     ready=0, rd_valid=0, rd_data=0, wr_collision=0.
//   INIT: each posedge writes 0 to every bank at the pointer, sets LVT[pointer]=0, increments the pointer.
//     The posedge that clears DEPTH-1 moves the FSM to RUN and sets ready=1.
//     ready is therefore visible after exactly DEPTH posedges with rst=1.
//     wr_en/rd_en are ignored in INIT; rd_valid stays 0.
//   RUN, write: each enabled port w writes bank[w][0..NR-1][addr] <= data and sets LVT[addr] <= w.
//   Same-address collision: the lowest-index enabled port wins; the other ports' writes are dropped entirely.
//     wr_collision=1 on the next cycle. Writes to distinct addresses all commit.
//   RUN, read: rd_en[r] sampled at edge N -> rd_data[r] and rd_valid[r] updated at edge N+1 (latency 1).
//     rd_data[r] = bank[LVT[a]][r][a], evaluated on the state before edge N's writes.
//     Exception: BYPASS=1 and a committed write to a at edge N -> return the winning port's wr_data.
//     rd_en[r]=0: rd_data[r] holds its last value; rd_valid[r]=0.
//   LVT width: max(1,$clog2(NW)). No arithmetic on data; all values are zero-extended.
//   Clear pointer is AW+1 bits wide; it never wraps in RUN.
//   Reset mid-operation, in INIT or RUN: returns to INIT at pointer 0 and discards any in-flight read.
//     All contents are cleared again before ready=1.
//   Reset has priority over all other inputs.
// TESTING  (AW=4, DW=8, NW=2, NR=2 unless noted)
//   1 Release rst, idle -> ready=0 for 15 posedges, 1 at the 16th; then rd addr 5 -> rd_data 0x00, rd_valid 1 cycle later.
//   2 wr0 a=10 d=0x05; next cycle wr1 a=10 d=0x09; rd0 a=10 -> 0x09. Then wr0 a=10 d=0x11 -> rd 0x11.
//   3 Same cycle wr0 a=3 d=0x33 and wr1 a=3 d=0x77 -> wr_collision=1 for one cycle; rd a=3 -> 0x33.
//   4 Same cycle wr1 a=7 d=0xAA and rd0 a=7 (old 0x00) -> BYPASS=0 returns 0x00; BYPASS=1 returns 0xAA.
//   5 Pre-load a=1 -> 0x12, a=2 -> 0x34; rd0 a=1 and rd1 a=2 in the same cycle -> 0x12 / 0x34 next cycle, both rd_valid=1.
//   6 After writes, assert rst in RUN and again at INIT cycle 5 -> ready stays 0 and returns 16 cycles after final release; prior data reads 0x00.

Source files
------------

// File: rtl/lvt_mpram.sv
// Multi-port RAM built from NW x NR replicated banks plus a Live Value Table
// that remembers which write port last wrote each address.
module lvt_mpram #(
  parameter int NW     = 2,
  parameter int NR     = 1,
  parameter int AW     = 7,
  parameter int DW     = 8,
  parameter int BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [NW-1:0]    wr_en,
  input  logic [NR*AW-1:0] rd_addr,
  input  logic [NR-1:0]    rd_en,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_valid,
  output logic             ready,
  output logic             wr_collision
);

  localparam int DEPTH = 2 ** AW;
  localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [AW:0]     ptr_q, ptr_d;
  logic [NR*DW-1:0] rd_data_q, rd_data_d;
  logic [NR-1:0]   rd_valid_q, rd_valid_d;
  logic            coll_q, coll_d;

  logic [DW-1:0]   bank_q [NW][NR][DEPTH];
  logic [LW-1:0]   lvt_q  [DEPTH];

  logic [NW-1:0]   commit;
  logic [NW-1:0]   bk_we;
  logic [AW-1:0]   bk_addr [NW];
  logic [DW-1:0]   bk_data [NW];
  logic [LW-1:0]   lvt_data [NW];
  logic [AW-1:0]   rd_a [NR];

  // Lowest-index enabled port wins an address; later ports hitting it are dropped.
  always_comb begin
    commit = '0;
    coll_d = 1'b0;
    for (int w = 0; w < NW; w++) begin
      commit[w] = wr_en[w];
      for (int v = 0; v < w; v++) begin
        if (wr_en[v] && (wr_addr[v*AW +: AW] == wr_addr[w*AW +: AW])) begin
          commit[w] = 1'b0;
        end
      end
      if (wr_en[w] && !commit[w]) begin
        coll_d = 1'b1;
      end
    end
    if (state_q != ST_RUN) begin
      commit = '0;
      coll_d = 1'b0;
    end
  end

  // During INIT every bank port is hijacked to clear the pointer address.
  always_comb begin
    for (int w = 0; w < NW; w++) begin
      if (state_q == ST_INIT) begin
        bk_we[w]    = 1'b1;
        bk_addr[w]  = ptr_q[AW-1:0];
        bk_data[w]  = '0;
        lvt_data[w] = '0;
      end else begin
        bk_we[w]    = commit[w];
        bk_addr[w]  = wr_addr[w*AW +: AW];
        bk_data[w]  = wr_data[w*DW +: DW];
        lvt_data[w] = LW'(w);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == (AW + 1)'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int r = 0; r < NR; r++) begin
      rd_a[r] = rd_addr[r*AW +: AW];
      if ((state_q == ST_RUN) && rd_en[r]) begin
        rd_valid_d[r]          = 1'b1;
        rd_data_d[r*DW +: DW]  = bank_q[lvt_q[rd_a[r]]][r][rd_a[r]];
        if (BYPASS != 0) begin
          for (int w = NW - 1; w >= 0; w--) begin
            if (commit[w] && (bk_addr[w] == rd_a[r])) begin
              rd_data_d[r*DW +: DW] = wr_data[w*DW +: DW];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      coll_q     <= coll_d;
    end
  end

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NW; w++) begin
      if (rst && bk_we[w]) begin
        for (int r = 0; r < NR; r++) begin
          bank_q[w][r][bk_addr[w]] <= bk_data[w];
        end
        lvt_q[bk_addr[w]] <= lvt_data[w];
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign wr_collision = coll_q;
  assign ready        = (state_q == ST_RUN);

endmodule

// File: tb/tb_lvt_mpram.sv
// Scoreboard bench for lvt_mpram: one instance without bypass, one with,
// sharing all inputs; reads push expected data, a monitor pops on rd_valid.
module tb_lvt_mpram;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_en;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_en;
  logic [15:0] rd_data_b0, rd_data_b1;
  logic [1:0]  rd_valid_b0, rd_valid_b1;
  logic        ready_b0, ready_b1;
  logic        coll_b0, coll_b1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] q_b0_r0 [$];
  logic [7:0] q_b0_r1 [$];
  logic [7:0] q_b1_r0 [$];
  logic [7:0] q_b1_r1 [$];

  lvt_mpram #(.NW(2), .NR(2), .AW(4), .DW(8), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data_b0), .rd_valid(rd_valid_b0),
    .ready(ready_b0), .wr_collision(coll_b0)
  );

  lvt_mpram #(.NW(2), .NR(2), .AW(4), .DW(8), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data_b1), .rd_valid(rd_valid_b1),
    .ready(ready_b1), .wr_collision(coll_b1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic popCheck(input int idx, input logic [7:0] actual);
    logic [7:0] exp_v;
    logic       have;
    have  = 1'b0;
    exp_v = '0;
    case (idx)
      0: if (q_b0_r0.size() > 0) begin have = 1'b1; exp_v = q_b0_r0.pop_front(); end
      1: if (q_b0_r1.size() > 0) begin have = 1'b1; exp_v = q_b0_r1.pop_front(); end
      2: if (q_b1_r0.size() > 0) begin have = 1'b1; exp_v = q_b1_r0.pop_front(); end
      default: if (q_b1_r1.size() > 0) begin have = 1'b1; exp_v = q_b1_r1.pop_front(); end
    endcase
    if (!have) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL unexpected_rd_valid idx=%0d: got data 0x%0h, required no valid", idx, actual);
    end else begin
      checkOutput($sformatf("rd_data idx=%0d", idx), {24'h0, actual}, {24'h0, exp_v});
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid_b0[0] === 1'b1) popCheck(0, rd_data_b0[7:0]);
    if (rd_valid_b0[1] === 1'b1) popCheck(1, rd_data_b0[15:8]);
    if (rd_valid_b1[0] === 1'b1) popCheck(2, rd_data_b1[7:0]);
    if (rd_valid_b1[1] === 1'b1) popCheck(3, rd_data_b1[15:8]);
  end

  // One cycle of stimulus; expected read data given per instance and port.
  task automatic applyStimulus(
      input logic [1:0] wen, input logic [3:0] wa0, input logic [7:0] wd0,
      input logic [3:0] wa1, input logic [7:0] wd1,
      input logic [1:0] ren, input logic [3:0] ra0, input logic [3:0] ra1,
      input logic [7:0] e0_b0, input logic [7:0] e1_b0,
      input logic [7:0] e0_b1, input logic [7:0] e1_b1,
      input logic exp_coll);
    wr_en   = wen;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_en   = ren;
    rd_addr = {ra1, ra0};
    if (ren[0]) begin q_b0_r0.push_back(e0_b0); q_b1_r0.push_back(e0_b1); end
    if (ren[1]) begin q_b0_r1.push_back(e1_b0); q_b1_r1.push_back(e1_b1); end
    @(posedge clk);
    #1;
    wr_en = 2'b00;
    rd_en = 2'b00;
    checkOutput("wr_collision", {30'h0, coll_b1, coll_b0}, {30'h0, exp_coll, exp_coll});
  endtask

  task automatic waitInit(input logic drive_junk);
    for (int i = 0; i < 16; i++) begin
      if (drive_junk) begin
        wr_en = 2'b11; wr_addr = 8'h54; wr_data = 16'h6655;
        rd_en = 2'b11; rd_addr = 8'h44;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("ready init cycle %0d", i + 1), {30'h0, ready_b1, ready_b0},
                  (i == 15) ? 32'h3 : 32'h0);
    end
    wr_en = 2'b00;
    rd_en = 2'b00;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", {30'h0, ready_b1, ready_b0}, 32'h0);
    checkOutput("reset rd_valid", {28'h0, rd_valid_b1, rd_valid_b0}, 32'h0);
    checkOutput("reset rd_data", {rd_data_b1, rd_data_b0}, 32'h0);
    checkOutput("reset coll", {30'h0, coll_b1, coll_b0}, 32'h0);

    // Clear sweep then read of a cleared address
    rst = 1'b1;
    waitInit(1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b01, 4'd5, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Last writer tracked across ports
    applyStimulus(2'b01, 4'd10, 8'h05, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(2'b10, 4'd0, 8'h00, 4'd10, 8'h09, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd10, 4'd10, 8'h09, 8'h09, 8'h09, 8'h09, 1'b0);
    applyStimulus(2'b01, 4'd10, 8'h11, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b01, 4'd10, 4'd0, 8'h11, 8'h00, 8'h11, 8'h00, 1'b0);

    // Same-address collision: port 0 wins, pulse lasts one cycle
    applyStimulus(2'b11, 4'd3, 8'h33, 4'd3, 8'h77, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd3, 4'd3, 8'h33, 8'h33, 8'h33, 8'h33, 1'b0);

    // Read during write: old data without bypass, new data with it
    applyStimulus(2'b10, 4'd0, 8'h00, 4'd7, 8'hAA, 2'b01, 4'd7, 4'd0, 8'h00, 8'h00, 8'hAA, 8'h00, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b01, 4'd7, 4'd0, 8'hAA, 8'h00, 8'hAA, 8'h00, 1'b0);
    applyStimulus(2'b11, 4'd9, 8'h01, 4'd9, 8'h02, 2'b10, 4'd0, 4'd9, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b01, 4'd9, 4'd0, 8'h01, 8'h00, 8'h01, 8'h00, 1'b0);

    // Distinct addresses both commit; two read ports in parallel; data holds when idle
    applyStimulus(2'b11, 4'd1, 8'h12, 4'd2, 8'h34, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd1, 4'd2, 8'h12, 8'h34, 8'h12, 8'h34, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("hold rd_data", {rd_data_b1, rd_data_b0}, 32'h3412_3412);
    checkOutput("hold rd_valid", {28'h0, rd_valid_b1, rd_valid_b0}, 32'h0);

    // Reset in RUN, then again five cycles into INIT; writes/reads ignored during INIT
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst in run ready", {30'h0, ready_b1, ready_b0}, 32'h0);
    checkOutput("rst in run rd_data", {rd_data_b1, rd_data_b0}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("ready partial init", {30'h0, ready_b1, ready_b0}, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    waitInit(1'b1);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd10, 4'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    applyStimulus(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 2'b11, 4'd4, 4'd7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained",
                q_b0_r0.size() + q_b0_r1.size() + q_b1_r0.size() + q_b1_r1.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
